// File: rtl/riscv_bp_ctrl.sv
// Write-port controller for the branch-prediction pattern table: clears the
// table after reset/flush, buffers branch-unit updates and gates prediction use.
module riscv_bp_ctrl #(
  parameter int          ADR_BITS   = 12,
  parameter logic [1:0]  INIT_VALUE = 2'b01,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                flush_i,
  input  logic                upd_valid_i,
  input  logic [ADR_BITS-1:0] upd_addr_i,
  input  logic [1:0]          upd_data_i,
  output logic                upd_drop_o,
  output logic                ram_we_o,
  output logic [ADR_BITS-1:0] ram_waddr_o,
  output logic [1:0]          ram_wdata_o,
  output logic                busy_o,
  output logic                bp_valid_o
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [ADR_BITS-1:0] LAST_ADR = '1;
  localparam logic [PW:0]         FULL_CNT = (PW+1)'(FIFO_DEPTH);

  typedef enum logic {CLEAR, RUN} state_e;

  state_e              state_q, state_d;
  logic [ADR_BITS-1:0] cnt_q, cnt_d;
  logic [PW-1:0]       rd_q, rd_d, wr_q, wr_d;
  logic [PW:0]         fcnt_q, fcnt_d;
  logic [ADR_BITS+1:0] fifo_q [FIFO_DEPTH];

  logic                we_q, we_d, drop_q, drop_d, bpv_q, bpv_d;
  logic [ADR_BITS-1:0] waddr_q, waddr_d;
  logic [1:0]          wdata_q, wdata_d;
  logic                push, pop, full, empty;

  assign full  = (fcnt_q == FULL_CNT);
  assign empty = (fcnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    fcnt_d  = fcnt_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    drop_d  = 1'b0;
    bpv_d   = (state_q == RUN);
    push    = 1'b0;
    pop     = 1'b0;
    if (flush_i) begin
      // The flush cycle issues no write; the restarted walk begins next cycle.
      state_d = CLEAR;
      cnt_d   = '0;
      rd_d    = '0;
      wr_d    = '0;
      fcnt_d  = '0;
      drop_d  = upd_valid_i;
      bpv_d   = 1'b0;
    end else if (state_q == CLEAR) begin
      we_d    = 1'b1;
      waddr_d = cnt_q;
      wdata_d = INIT_VALUE;
      cnt_d   = cnt_q + 1'b1;
      if (cnt_q == LAST_ADR) state_d = RUN;
      if (upd_valid_i) begin
        if (full) drop_d = 1'b1;
        else      push   = 1'b1;
      end
    end else if (!empty) begin
      // Drain in arrival order; a concurrent update queues behind the head.
      pop                = 1'b1;
      we_d               = 1'b1;
      {waddr_d, wdata_d} = fifo_q[rd_q];
      rd_d               = rd_q + 1'b1;
      push               = upd_valid_i;
    end else if (upd_valid_i) begin
      we_d    = 1'b1;
      waddr_d = upd_addr_i;
      wdata_d = upd_data_i;
    end
    if (push) wr_d = wr_q + 1'b1;
    if (push && !pop)      fcnt_d = fcnt_q + 1'b1;
    else if (pop && !push) fcnt_d = fcnt_q - 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      fcnt_q  <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      drop_q  <= 1'b0;
      bpv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      fcnt_q  <= fcnt_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      drop_q  <= drop_d;
      bpv_q   <= bpv_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wr_q] <= {upd_addr_i, upd_data_i};
  end

  assign upd_drop_o  = drop_q;
  assign ram_we_o    = we_q;
  assign ram_waddr_o = waddr_q;
  assign ram_wdata_o = wdata_q;
  assign busy_o      = (state_q == CLEAR);
  assign bp_valid_o  = bpv_q;

endmodule

// File: tb/tb_riscv_bp_ctrl.sv
// Bench for riscv_bp_ctrl: directed scenarios plus random traffic, each cycle
// compared against a queue-based reference model of the table controller.
module tb_riscv_bp_ctrl;
  localparam int AB = 4;
  localparam int N  = 1 << AB;

  logic          clk = 1'b0;
  logic          rst, flush, uv;
  logic [AB-1:0] ua;
  logic [1:0]    ud;
  logic          drop, we, busy, bpv;
  logic [AB-1:0] waddr;
  logic [1:0]    wdata;

  riscv_bp_ctrl #(.ADR_BITS(AB), .INIT_VALUE(2'b01), .FIFO_DEPTH(4)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .upd_valid_i(uv),
    .upd_addr_i(ua), .upd_data_i(ud), .upd_drop_o(drop), .ram_we_o(we),
    .ram_waddr_o(waddr), .ram_wdata_o(wdata), .busy_o(busy), .bp_valid_o(bpv)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: clearing flag, walk index, and the pending-update queue.
  bit           m_clr = 1'b1;
  int           m_idx = 0;
  logic [5:0]   m_q[$];
  logic [9:0]   exp_v;

  function automatic logic [9:0] obs_vec();
    return {we, we ? waddr : 4'h0, we ? wdata : 2'b00, drop, busy, bpv};
  endfunction

  // Applies one cycle of inputs, predicts the post-edge outputs, and advances.
  task automatic tick(input logic r, input logic f, input logic v,
                      input logic [AB-1:0] a, input logic [1:0] d);
    logic e_we, e_drop, e_bpv;
    logic [AB-1:0] e_a;
    logic [1:0] e_d;
    e_we = 1'b0; e_drop = 1'b0; e_bpv = 1'b0; e_a = '0; e_d = '0;
    rst = r; flush = f; uv = v; ua = a; ud = d;
    if (r) begin
      m_clr = 1'b1; m_idx = 0; m_q.delete();
    end else begin
      e_bpv = !m_clr && !f;
      if (f) begin
        e_drop = v; m_clr = 1'b1; m_idx = 0; m_q.delete();
      end else if (m_clr) begin
        e_we = 1'b1; e_a = AB'(m_idx); e_d = 2'b01;
        if (v) begin
          if (m_q.size() == 4) e_drop = 1'b1;
          else m_q.push_back({a, d});
        end
        m_idx++;
        if (m_idx == N) begin m_clr = 1'b0; m_idx = 0; end
      end else if (m_q.size() > 0) begin
        {e_a, e_d} = m_q.pop_front();
        e_we = 1'b1;
        if (v) m_q.push_back({a, d});
      end else if (v) begin
        e_we = 1'b1; e_a = a; e_d = d;
      end
    end
    exp_v = {e_we, e_a, e_d, e_drop, m_clr, e_bpv};
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b0, 1'b0, '0, '0);
      checks++;
      if (obs_vec() !== exp_v || waddr !== 4'h0 || wdata !== 2'b00) begin
        errors++;
        $display("FAIL reset cyc%0d got=%b addr=%h data=%b exp=%b", i, obs_vec(), waddr, wdata, exp_v);
      end
    end
  endtask

  task automatic test_walk();
    int nwe = 0;
    for (int i = 0; i < N + 6; i++) begin
      tick(1'b0, 1'b0, 1'b0, '0, '0);
      if (we) nwe++;
      checks++;
      if (obs_vec() !== exp_v) begin
        errors++; $display("FAIL walk cyc%0d got=%b exp=%b", i, obs_vec(), exp_v);
      end
    end
    checks++;
    if (nwe !== N) begin
      errors++; $display("FAIL walk_count got=%0d exp=%0d", nwe, N);
    end
  endtask

  task automatic test_bypass();
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 1'b0, i == 1, (i == 1) ? 4'd5 : 4'd0, (i == 1) ? 2'b11 : 2'b00);
      checks++;
      if (obs_vec() !== exp_v) begin
        errors++; $display("FAIL bypass cyc%0d got=%b exp=%b", i, obs_vec(), exp_v);
      end
    end
  endtask

  task automatic test_clear_buffer();
    tick(1'b1, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < N + 10; i++) begin
      tick(1'b0, 1'b0, i < 6, AB'(i + 1), 2'(i));
      checks++;
      if (obs_vec() !== exp_v) begin
        errors++; $display("FAIL clear_buffer cyc%0d got=%b exp=%b", i, obs_vec(), exp_v);
      end
    end
  endtask

  task automatic test_back_to_back();
    tick(1'b1, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < N + 12; i++) begin
      tick(1'b0, 1'b0, (i >= N - 4) && (i < N + 3), AB'(i), 2'(i + 1));
      checks++;
      if (obs_vec() !== exp_v) begin
        errors++; $display("FAIL back_to_back cyc%0d got=%b exp=%b", i, obs_vec(), exp_v);
      end
    end
  endtask

  task automatic test_flush();
    tick(1'b1, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 10 + N + 2; i++) begin
      // flush at walk index 9 with an update, then 3 updates buffered at the
      // walk's end and a flush on the first RUN cycle
      tick(1'b0, (i == 9) || (i == 10 + N), (i == 9) || (i >= 10 + N - 3 && i < 10 + N),
           AB'(i), 2'b10);
      checks++;
      if (obs_vec() !== exp_v) begin
        errors++; $display("FAIL flush cyc%0d got=%b exp=%b", i, obs_vec(), exp_v);
      end
    end
    for (int i = 0; i < N + 4; i++) begin
      tick(1'b0, 1'b0, 1'b0, '0, '0);
      checks++;
      if (obs_vec() !== exp_v) begin
        errors++; $display("FAIL flush_rewalk cyc%0d got=%b exp=%b", i, obs_vec(), exp_v);
      end
    end
  endtask

  task automatic test_reset_flush();
    tick(1'b1, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < N + 2 + N + 4; i++) begin
      tick(i == N + 1, i == N + 1, (i >= N - 4 && i < N + 2), AB'(i + 3), 2'b11);
      checks++;
      if (obs_vec() !== exp_v) begin
        errors++; $display("FAIL reset_flush cyc%0d got=%b exp=%b", i, obs_vec(), exp_v);
      end
    end
  endtask

  task automatic test_random();
    tick(1'b1, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 500; i++) begin
      tick(1'b0, $urandom_range(0, 149) == 0, $urandom_range(0, 99) < 60,
           AB'($urandom), 2'($urandom));
      checks++;
      if (obs_vec() !== exp_v) begin
        errors++; $display("FAIL random cyc%0d got=%b exp=%b", i, obs_vec(), exp_v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_walk();
    test_bypass();
    test_clear_buffer();
    test_back_to_back();
    test_flush();
    test_reset_flush();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
